// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants and the scoreboard entry type for the forwarding
// scoreboard (see forwarding_scoreboard.sv; optional macro FWD_STATS_EN).
package fwd_pkg;

    // Selector value meaning "read the register file"
    localparam int SEL_REGFILE = 0;

    // Downstream stage numbering; stage s result is selected with value s
    localparam int STAGE_MEM = 1;
    localparam int STAGE_WB  = 2;

    // Widest register address an entry can hold; REG_ADDR_W must not exceed it
    localparam int MAX_REG_ADDR_W = 8;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic                      valid;
        logic                      wb_en;
        logic                      is_load;
        logic [MAX_REG_ADDR_W-1:0] dest;
    } fwd_entry_t;

    // Bubble / reset value of an entry
    localparam fwd_entry_t ENTRY_EMPTY = '0;

endpackage

// File: rtl/fwd_stage_reg.sv
// fwd_stage_reg: one scoreboard entry register. Flush wins over advance;
// on advance the entry loads either the upstream entry or a bubble.
module fwd_stage_reg
    import fwd_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Advance,
    input  logic       i_Flush,
    input  logic       i_Bubble,
    input  fwd_entry_t i_D,
    output fwd_entry_t o_Q
);

    fwd_entry_t r_q;

    // Entry state: clear on reset/flush, shift on advance, otherwise hold
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        // NOTE: the entry is reset because its valid bit gates every hazard
        // decision; an unknown valid after power-up would stall or forward garbage.
        if (!i_Rst_n) begin
            // NOTE: non-blocking assignment so every stage samples its upstream
            // neighbour's pre-edge value and the chain shifts by exactly one.
            r_q <= ENTRY_EMPTY;
        end else if (i_Flush) begin
            r_q <= ENTRY_EMPTY;
        end else if (i_Advance) begin
            r_q <= i_Bubble ? ENTRY_EMPTY : i_D;
        end
    end

    assign o_Q = r_q;

endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: tracks in-flight writers in the downstream stages and
// produces per-source bypass selectors plus a hazard stall for the issue stage.
// Optional macro FWD_STATS_EN adds saturating stall / forward event counters.
module forwarding_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = STAGE_WB,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    input  logic                          i_Forwarding_Enable,
    input  logic                          i_Pipe_Advance,
    input  logic                          i_Flush,
    input  logic                          i_Issue_Valid,
    input  logic                          i_Issue_Write_Back_Enable,
    input  logic                          i_Issue_Is_Load,
    input  logic [REG_ADDR_W-1:0]         i_Issue_Destination,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] i_Src,
    input  logic [NUM_SRC-1:0]            i_Src_Valid,
    output logic [NUM_SRC*SEL_W-1:0]      o_Sel_Src,
`ifdef FWD_STATS_EN
    output logic [15:0]                   o_Stall_Count,
    output logic [15:0]                   o_Fwd_Count,
`endif
    output logic                          o_Stall
);

    fwd_entry_t               w_entry [1:FWD_DEPTH];
    fwd_entry_t               w_issue_entry;
    logic                     w_issue_accept;
    logic [FWD_DEPTH:1]       w_match [NUM_SRC];
    logic                     w_any_match;
    logic                     w_mem_match;
    logic                     w_load_use;
    logic [NUM_SRC*SEL_W-1:0] w_sel_src;

    // Pack the issuing instruction into an entry (dest zero-extended)
    always_comb begin
        w_issue_entry         = ENTRY_EMPTY;
        w_issue_entry.valid   = 1'b1;
        w_issue_entry.wb_en   = i_Issue_Write_Back_Enable;
        w_issue_entry.is_load = i_Issue_Is_Load;
        w_issue_entry.dest    = MAX_REG_ADDR_W'(i_Issue_Destination);
    end

    // A stalled or absent issue enters the pipeline as a bubble
    assign w_issue_accept = i_Issue_Valid && !o_Stall;

    // Entry chain: stage 1 takes the issue slot, stage s+1 takes stage s
    for (genvar s = 1; s <= FWD_DEPTH; s++) begin : g_stage
        fwd_entry_t w_d;
        logic       w_bubble;

        if (s == STAGE_MEM) begin : g_head
            assign w_d      = w_issue_entry;
            assign w_bubble = !w_issue_accept;
        end else begin : g_tail
            assign w_d      = w_entry[s-1];
            assign w_bubble = 1'b0;
        end

        fwd_stage_reg u_entry (
            .i_Clk     (i_Clk),
            .i_Rst_n   (i_Rst_n),
            .i_Advance (i_Pipe_Advance),
            .i_Flush   (i_Flush),
            .i_Bubble  (w_bubble),
            .i_D       (w_d),
            .o_Q       (w_entry[s])
        );
    end

    // Per-port, per-stage match against live writers
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int s = 1; s <= FWD_DEPTH; s++) begin
                w_match[k][s] = i_Src_Valid[k] && w_entry[s].valid && w_entry[s].wb_en &&
                                (w_entry[s].dest ==
                                 MAX_REG_ADDR_W'(i_Src[k*REG_ADDR_W +: REG_ADDR_W]));
            end
        end
    end

    // Bypass selectors: youngest matching stage wins, regfile otherwise
    always_comb begin
        // NOTE: every bit gets a default before the conditional loop so this
        // block stays purely combinational instead of inferring a latch.
        w_sel_src = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_sel_src[k*SEL_W +: SEL_W] = SEL_W'(SEL_REGFILE);
            if (i_Forwarding_Enable) begin
                for (int s = FWD_DEPTH; s >= 1; s--) begin
                    if (w_match[k][s]) begin
                        w_sel_src[k*SEL_W +: SEL_W] = SEL_W'(s);
                    end
                end
            end
        end
    end

    assign o_Sel_Src = w_sel_src;

    // Hazard summary across all ports
    always_comb begin
        w_any_match = 1'b0;
        w_mem_match = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_any_match = w_any_match | (|w_match[k]);
            w_mem_match = w_mem_match | w_match[k][STAGE_MEM];
        end
    end

    // Only a load in MEM cannot be bypassed; interlock mode stalls on any hit
    assign w_load_use = w_mem_match && w_entry[STAGE_MEM].is_load;
    assign o_Stall    = i_Issue_Valid && (i_Forwarding_Enable ? w_load_use : w_any_match);

`ifdef FWD_STATS_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_fwd_count;

    // Saturating event counters, sampled on advancing cycles only
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_stall_count <= '0;
            r_fwd_count   <= '0;
        end else if (i_Pipe_Advance) begin
            if (o_Stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if ((|w_sel_src) && (r_fwd_count != 16'hFFFF)) begin
                r_fwd_count <= r_fwd_count + 16'd1;
            end
        end
    end

    assign o_Stall_Count = r_stall_count;
    assign o_Fwd_Count   = r_fwd_count;
`endif

endmodule
